// File: rtl/sa_tx_pkg.sv
// sa_tx_pkg: shared constants, types and the slot allocation rule for the
// store-side transmit queue and its dispatcher.
//   SA_TX_N / SA_TX_W / SA_TX_IDX_W : slot count, entry width, slot index width
//   sa_tx_entry_t, sa_tx_idx_t      : entry payload and slot index types
//   sa_tx_state_e                   : dispatcher FSM states
//   sa_tx_lowest_free()             : lowest-free-slot encoder; the queue owner
//                                     calls the same function so both sides
//                                     always agree on which slot a write takes.
package sa_tx_pkg;

  localparam int SA_TX_N     = 8;
  localparam int SA_TX_W     = 57;
  localparam int SA_TX_IDX_W = $clog2(SA_TX_N);

  typedef logic [SA_TX_W-1:0]     sa_tx_entry_t;
  typedef logic [SA_TX_IDX_W-1:0] sa_tx_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } sa_tx_state_e;

  // Lowest index whose used bit is clear. Scanning downwards and overwriting
  // leaves the lowest hit. Result is 0 when every slot is used; callers gate
  // the allocation with !full, so that value is never acted on.
  function automatic sa_tx_idx_t sa_tx_lowest_free(input logic [SA_TX_N-1:0] used);
    sa_tx_idx_t idx;
    idx = '0;
    for (int i = SA_TX_N - 1; i >= 0; i--) begin
      if (!used[i]) idx = sa_tx_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sa_tx_order_fifo.sv
// sa_tx_order_fifo: DEPTH-deep FIFO of slot indices recording allocation
// order. Pointers carry one extra wrap bit so full and empty are distinct.
//   clk, rst      : clock, async active-high reset
//   push/push_idx : append a slot index
//   pop           : drop the head entry
//   empty         : no entries held
//   head          : oldest index (meaningful only while !empty)
// The owner guarantees no push while full and no pop while empty.
module sa_tx_order_fifo #(
  parameter int DEPTH = 8,
  parameter int IW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [IW-1:0] push_idx,
  input  logic          pop,
  output logic          empty,
  output logic [IW-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [IW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_idx;
  end

endmodule

// File: rtl/sa_tx_dispatch.sv
// sa_tx_dispatch: drains the store-side transmit queue oldest-first.
// Mirrors the queue's slot occupancy by snooping its write strobe, records
// the allocation order, streams entries onto a valid/ready port and returns
// a one-hot clear to the queue as each entry is accepted.
//   clk, rst          : clock, async active-high reset
//   we                : queue write strobe (snooped)
//   q_dat             : all queue slots in parallel
//   cr                : one-hot slot clear, high during the accepting cycle
//   full              : every slot occupied (combinational)
//   ovf               : sticky, a write was seen while full
//   tx_valid/tx_ready : transmit handshake
//   tx_data, tx_slot  : entry on the port and the slot it came from
// N must equal SA_TX_N so the shared encoder sees the same slot count.
module sa_tx_dispatch
  import sa_tx_pkg::*;
#(
  parameter int N  = SA_TX_N,
  parameter int W  = SA_TX_W,
  localparam int IW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [N-1:0][W-1:0] q_dat,
  output logic [N-1:0]        cr,
  output logic                full,
  output logic                ovf,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [W-1:0]        tx_data,
  output logic [IW-1:0]       tx_slot
);

  logic [N-1:0]  used;
  logic [N-1:0]  alloc_oh;
  logic          alloc;
  logic [IW-1:0] alloc_idx;
  logic          hs;
  logic          fifo_empty;
  logic [IW-1:0] fifo_head;
  logic          pop;

  sa_tx_state_e  state_q, state_d;

  // ---------------- occupancy mirror ----------------
  assign full      = &used;
  assign alloc     = we && !full;
  assign alloc_idx = sa_tx_lowest_free(used);
  assign alloc_oh  = alloc ? (N'(1) << alloc_idx) : '0;

  assign tx_valid  = (state_q == SEND);
  assign hs        = tx_valid && tx_ready;
  assign cr        = hs ? (N'(1) << tx_slot) : '0;

  // Allocation is chosen from the pre-edge mirror, and the slot being
  // released is still marked used there, so set and clear never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) used <= '0;
    else     used <= (used | alloc_oh) & ~cr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            ovf <= 1'b0;
    else if (we && full) ovf <= 1'b1;
  end

  // ---------------- allocation order ----------------
  // Holds allocated-but-not-loaded slots only, so it is bounded by N and
  // cannot overflow while pushes are gated by !full.
  sa_tx_order_fifo #(
    .DEPTH (N),
    .IW    (IW)
  ) u_order (
    .clk      (clk),
    .rst      (rst),
    .push     (alloc),
    .push_idx (alloc_idx),
    .pop      (pop),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  // ---------------- transmit FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Back-to-back: reload on the accepting edge when more is queued.
        if (hs) begin
          if (!fifo_empty) pop     = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The head slot was written by the queue at least one edge earlier, so
  // q_dat already holds its payload when it is loaded here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_data <= '0;
      tx_slot <= '0;
    end else if (pop) begin
      tx_data <= q_dat[fifo_head];
      tx_slot <= fifo_head;
    end
  end

endmodule

// File: tb/tb_sa_tx_dispatch.sv
module tb_sa_tx_dispatch;

  localparam int N = 8;
  localparam int W = 57;

  logic                clk = 1'b0;
  logic                rst;
  logic                we;
  logic [N-1:0][W-1:0] q_dat;
  logic [N-1:0]        cr;
  logic                full;
  logic                ovf;
  logic                tx_valid;
  logic                tx_ready;
  logic [W-1:0]        tx_data;
  logic [2:0]          tx_slot;
  logic [W-1:0]        wdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sa_tx_dispatch #(.N(N), .W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .q_dat    (q_dat),
    .cr       (cr),
    .full     (full),
    .ovf      (ovf),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_slot  (tx_slot)
  );

  // ---------------- reference model ----------------
  // Expected transmissions in allocation order; t = edge number of the write.
  typedef struct {
    logic [2:0]   slot;
    logic [W-1:0] data;
    int           t;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] mused;
  bit         movf;
  int         ecnt;
  bit         exp_v;

  function automatic int lowfree(input logic [7:0] u);
    for (int i = 0; i < 8; i++) if (!u[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of the queue plus the dispatcher's observable contract. The bench
  // plays the queue, so it also owns q_dat.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sbq.delete();
      mused = '0;
      movf  = 0;
      ecnt  = 0;
      exp_v = 0;
      q_dat <= '0;
    end else begin : model_step
      bit hs;
      int s;
      hs = exp_v && tx_ready;
      ecnt++;
      if (we) begin
        s = lowfree(mused);
        if (s < 0) movf = 1;
        else begin
          mused[s] = 1'b1;
          q_dat[s] <= wdata;
          sbq.push_back('{slot: 3'(s), data: wdata, t: ecnt});
        end
      end
      if (hs) begin
        mused[sbq[0].slot] = 1'b0;
        q_dat[sbq[0].slot] <= '0;
        void'(sbq.pop_front());
      end
    end
  end

  // Monitor: an entry is presentable from the edge after its write onward.
  always @(negedge clk) begin
    if (!rst) begin : mon
      logic [7:0] ecr;
      exp_v = (sbq.size() > 0) && (sbq[0].t < ecnt);
      chk("tx_valid", 64'(tx_valid), 64'(exp_v));
      ecr = '0;
      if (exp_v) begin
        chk("tx_slot", 64'(tx_slot), 64'(sbq[0].slot));
        chk("tx_data", 64'(tx_data), 64'(sbq[0].data));
        if (tx_ready) ecr = 8'(1) << sbq[0].slot;
      end
      chk("cr", 64'(cr), 64'(ecr));
      chk("full", 64'(full), 64'(&mused));
      chk("ovf", 64'(ovf), 64'(movf));
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [W-1:0] rnd57();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  task automatic cycd(input logic w, input logic r, input logic [W-1:0] d);
    we       = w;
    tx_ready = r;
    wdata    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic w, input logic r);
    cycd(w, r, rnd57());
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sbq.size() > 0 && k < 100) begin
      cyc(1'b0, 1'b1);
      k++;
    end
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left after %0d cycles, expected 0", sbq.size(), k);
    end
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; tx_ready = 1'b0; wdata = '0;
    #1 rst = 1'b1;
    #12;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_cr", 64'(cr), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_slot", 64'(tx_slot), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // single entry
    cycd(1'b1, 1'b1, 57'h1_2345_6789_ABCD);
    repeat (3) cyc(1'b0, 1'b1);

    // fill to full, one write past full, then drain in order
    repeat (8) cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    drain();

    // hole reuse: 0..3 written, 0 and 1 released, two writes refill 0 and 1
    repeat (4) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    drain();

    // write in the same cycle as the release of slot 0
    repeat (3) cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    drain();

    // random traffic with random backpressure; writer respects full
    repeat (300) cyc(($urandom_range(0, 3) != 0) && !(&mused), 1'($urandom_range(0, 1)));
    drain();

    // async reset while an entry is on the port
    repeat (3) cyc(1'b1, 1'b0);
    repeat (2) cyc(1'b0, 1'b0);
    tx_ready = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_valid", 64'(tx_valid), 64'd0);
    chk("arst_cr", 64'(cr), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    #1 rst = 1'b0;
    cyc(1'b1, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sa_tx_dispatch.md
# sa_tx_dispatch

Downstream consumer of the store-side transmit queue register file. Mirrors the queue's slot occupancy by snooping its write strobe with the same lowest-free-slot rule, and records allocation order. Drains entries oldest-first onto a valid/ready transmit port, and returns a one-hot clear to the queue when each entry is accepted. Also drives `full` back to the queue's producer, so no write is issued into a full queue.

## Interface
- `N`, 8, number of queue slots; must match the queue.
- `W`, 57, entry width in bits.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `we` in 1: the queue's write strobe, snooped; one slot allocated per cycle it is high.
- `q_dat` in N×W: the queue's `dat_out` array, all slots in parallel.
- `cr` out N: one-hot slot clear to the queue; zero when idle.
- `full` out 1: all N slots occupied, combinational from the occupancy mirror.
- `ovf` out 1: sticky; set when `we` is seen while `full`; cleared only by reset.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts when high together with `tx_valid`.
- `tx_data` out W: entry being transmitted.
- `tx_slot` out log2(N): slot index of the current entry, for debug/trace.

## Operation
- **Occupancy mirror:** `used[N-1:0]`.
  - On `we` with `!full`: allocate `idx` = lowest index with `used[idx]==0`. This matches the queue's priority encoder exactly.
  - Set `used[idx]` and push `idx` into the order FIFO.
- **Write while full:** `we` with `full` allocates nothing, pushes nothing and sets `ovf`.
- **Release:** on handshake (`tx_valid && tx_ready`), pulse `cr = 1<<tx_slot` for exactly one cycle and clear `used[tx_slot]`.
- **Allocate and release in the same cycle:** allocation uses the pre-edge `used`. A slot freed this cycle is not reusable until the next cycle. The set and clear target different bits, so there is no conflict.
- **FSM, two states:**
  - **IDLE:** `tx_valid=0`. If the order FIFO is non-empty, pop the head `h`, load `tx_data <= q_dat[h]` and `tx_slot <= h`, then go to SEND.
  - **SEND:** `tx_valid=1`. Hold `tx_data` and `tx_slot` stable until handshake.
    - On handshake with the FIFO non-empty: pop and load the next entry, stay in SEND (back-to-back).
    - On handshake with the FIFO empty: go to IDLE.
- **Order FIFO:** depth N, each entry log2(N) bits, circular with wrap-around. It never overflows, because pushes are gated by `!full` and the FIFO holds only entries that are allocated but not yet loaded.
- **Reset values:** `used=0`, FIFO empty, state IDLE, `cr=0`, `full=0`, `ovf=0`, `tx_valid=0`, `tx_data=0`, `tx_slot=0`.
- **Reset mid-transfer:** all state is dropped immediately and asynchronously. The queue must be reset in the same domain.

## Timing
- `we` sampled at edge E0 → the queue writes the slot at E0 and `idx` is pushed at E0.
- At E1 (FSM in IDLE): the entry is loaded and `tx_valid` is high after E1. The latency is one cycle.
- Handshake sampled at edge Ek → `cr` is high in the cycle before Ek and combinational from the handshake. The queue clears the slot at Ek, and `used` is cleared at Ek.
- Sustained throughput is one entry per cycle while `tx_ready` is held high and the FIFO is non-empty.
- `full` follows `used` combinationally. The producer must not assert `we` in a cycle where `full` is high.

## Structure
- Package `sa_tx_pkg` holds:
  - `SA_TX_N`, `SA_TX_W`, `SA_TX_IDX_W`;
  - the typedefs `sa_tx_entry_t` (W bits) and `sa_tx_idx_t`;
  - the FSM enum `{IDLE, SEND}`.
- One sub-module, `sa_tx_order_fifo`: an N-deep FIFO of indices with push/pop/empty and head output, using pointers one bit wider than log2(N) to distinguish full from empty.
- The lowest-free-slot encoder is a function in the package, shared with the queue owner for consistency.

## Test plan
- **Single entry:** `we` at E0 with payload 0x1_2345_6789_ABCD into an empty queue.
  - Required: `tx_valid` after E1 with `tx_slot=0`.
  - With `tx_ready=1`: `cr=8'h01` for one cycle, `used=0` afterwards.
- **Fill to full and drain:** 8 consecutive `we` with `tx_ready=0`.
  - Required: `full=1` after the eighth. A ninth `we` sets `ovf=1`, and the queue contents are unchanged.
  - Then raise `tx_ready`: slots 0..7 are sent in order on 8 consecutive cycles, `cr` walks 0x01→0x80, and `full` drops after the first release.
- **Hole reuse and ordering:** fill slots 0–3 and release 0 and 1, then write twice more.
  - Required: the new entries take slots 0 then 1.
  - Transmit order is 2, 3, 0, 1.
- **Simultaneous alloc/release:** `we` in the same cycle as a handshake on slot 0, with slots 0–2 used.
  - Required: allocation goes to slot 3, not 0, and slot 0 is free on the next cycle.
- **Backpressure:** toggle `tx_ready` randomly.
  - Required: `tx_data` and `tx_slot` are stable while `tx_valid && !tx_ready`, and `cr` is never non-zero outside a handshake.
- **Async reset in SEND:** assert `rst` between edges while the FSM is in SEND.
  - Required: `tx_valid`, `cr` and `full` go to 0 immediately, and the next `we` after reset allocates slot 0.
